// File: rtl/fpu_operand_loader_pkg.sv
// Shared types and constants for the FPU operand loader: controller state
// encoding, FPU status codes and the operand word format.
package fpu_operand_loader_pkg;

  typedef enum logic [2:0] {
    LOAD_A  = 3'd0,
    LOAD_B  = 3'd1,
    HOLD    = 3'd2,
    CAPTURE = 3'd3,
    DONE    = 3'd4
  } state_t;

  // One-hot FPU status codes.
  localparam logic [3:0] EXACT     = 4'b0001;
  localparam logic [3:0] INEXACT   = 4'b0010;
  localparam logic [3:0] OVERFLOW  = 4'b0100;
  localparam logic [3:0] UNDERFLOW = 4'b1000;

  // Operand word: 1 sign bit, EXP_W exponent bits (bias BIAS), MANT_W mantissa bits.
  localparam int EXP_W  = 6;
  localparam int MANT_W = 25;
  localparam int BIAS   = 31;
  localparam int WORD_W = 1 + EXP_W + MANT_W;

endpackage

// File: rtl/fpu_operand_loader_byte_shift_collector.sv
// Assembles 32-bit words from a byte stream, MSB byte first. The completed
// word is presented combinationally together with the word_done pulse so the
// owner can latch it on the same edge that accepts the fourth byte.
module byte_shift_collector
  import fpu_operand_loader_pkg::*;
(
  input  logic              clock100KHz,
  input  logic              reset,
  input  logic              accept,
  input  logic [7:0]        byte_in,
  output logic [WORD_W-1:0] word,
  output logic              word_done
);

  logic [WORD_W-1:0] shadow;
  logic [1:0]        byte_count;

  // Shift accepted bytes in from the LSB end; the counter wraps 3 -> 0.
  always_ff @(posedge clock100KHz or negedge reset) begin
    if (!reset) begin
      shadow     <= '0;
      byte_count <= 2'd0;
    end else if (accept) begin
      shadow     <= {shadow[WORD_W-9:0], byte_in};
      byte_count <= byte_count + 2'd1;
    end
  end

  // The word as it will look once the byte on the bus is shifted in.
  always_comb begin
    word      = {shadow[WORD_W-9:0], byte_in};
    word_done = accept && (byte_count == 2'd3);
  end

endmodule

// File: rtl/fpu_operand_loader.sv
// Loads two operand words from a byte stream, holds them at the FPU for
// HOLD_CYCLES cycles, captures the FPU result and status, and keeps the
// result valid until the consumer acknowledges it.
//
// Byte handshake: a byte transfers on a rising edge where byte_valid and
// byte_ready are both high. byte_ready depends only on state, never on
// byte_valid. Outside LOAD_A/LOAD_B byte_ready is low and bytes stay on the
// bus unconsumed. result_valid stays high from CAPTURE until a result_ack
// is seen in DONE; result_ack in any other state has no effect.
module fpu_operand_loader
  import fpu_operand_loader_pkg::*;
#(
  parameter int HOLD_CYCLES = 10
) (
  input  logic        clock100KHz,
  input  logic        reset,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic [31:0] op_A_out,
  output logic [31:0] op_B_out,
  input  logic [31:0] fpu_data_in,
  input  logic [3:0]  fpu_status_in,
  output logic [31:0] result_out,
  output logic [3:0]  status_out,
  output logic        result_valid,
  input  logic        result_ack,
  output logic        busy,
  output state_t      state_dbg
);

  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

  state_t      state;
  state_t      state_next;
  logic [7:0]  hold_cnt;
  logic        accept;
  logic [31:0] word;
  logic        word_done;

  assign accept    = byte_valid && byte_ready;
  assign state_dbg = state;

  byte_shift_collector u_collector (
    .clock100KHz (clock100KHz),
    .reset       (reset),
    .accept      (accept),
    .byte_in     (byte_in),
    .word        (word),
    .word_done   (word_done)
  );

  // State register.
  always_ff @(posedge clock100KHz or negedge reset) begin
    if (!reset) state <= LOAD_A;
    else        state <= state_next;
  end

  // Next-state decode plus the state-derived handshake and busy flags.
  always_comb begin
    state_next = state;
    byte_ready = 1'b0;
    busy       = 1'b1;
    case (state)
      LOAD_A: begin
        byte_ready = 1'b1;
        busy       = 1'b0;
        if (word_done) state_next = LOAD_B;
      end
      LOAD_B: begin
        byte_ready = 1'b1;
        if (word_done) state_next = HOLD;
      end
      HOLD: begin
        if (hold_cnt == 8'd0) state_next = CAPTURE;
      end
      CAPTURE: begin
        state_next = DONE;
      end
      DONE: begin
        if (result_ack) state_next = LOAD_A;
      end
      default: begin
        state_next = LOAD_A;
      end
    endcase
  end

  // Operand, hold-counter and result registers; each keeps its value until
  // the state that owns it overwrites it.
  always_ff @(posedge clock100KHz or negedge reset) begin
    if (!reset) begin
      op_A_out     <= '0;
      op_B_out     <= '0;
      hold_cnt     <= '0;
      result_out   <= '0;
      status_out   <= '0;
      result_valid <= 1'b0;
    end else begin
      if (state == LOAD_A && word_done) begin
        op_A_out <= word;
      end
      if (state == LOAD_B && word_done) begin
        op_B_out <= word;
        hold_cnt <= HOLD_LOAD;
      end
      if (state == HOLD && hold_cnt != 8'd0) begin
        hold_cnt <= hold_cnt - 8'd1;
      end
      if (state == CAPTURE) begin
        result_out   <= fpu_data_in;
        status_out   <= fpu_status_in;
        result_valid <= 1'b1;
      end
      if (state == DONE && result_ack) begin
        result_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fpu_operand_loader.sv
// Bench for fpu_operand_loader: byte-level driver tasks, a reference model of
// the operand/result registers, and a result scoreboard keyed on the edge
// at which result_valid is expected to rise.
module tb_fpu_operand_loader;
  import fpu_operand_loader_pkg::*;

  localparam int HOLD = 10;

  logic        clock100KHz = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  byte_in = '0;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic [31:0] op_A_out;
  logic [31:0] op_B_out;
  logic [31:0] fpu_data_in = '0;
  logic [3:0]  fpu_status_in = '0;
  logic [31:0] result_out;
  logic [3:0]  status_out;
  logic        result_valid;
  logic        result_ack = 1'b0;
  logic        busy;
  state_t      state_dbg;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Expected results: {edge number of result_valid rise, status, data}.
  logic [67:0] exp_q[$];

  // Reference model of the architecturally visible registers.
  logic [31:0] model_a = '0;
  logic [31:0] model_b = '0;
  logic [31:0] model_res = '0;
  logic [3:0]  model_stat = '0;

  fpu_operand_loader #(.HOLD_CYCLES(HOLD)) dut (
    .clock100KHz   (clock100KHz),
    .reset         (reset),
    .byte_in       (byte_in),
    .byte_valid    (byte_valid),
    .byte_ready    (byte_ready),
    .op_A_out      (op_A_out),
    .op_B_out      (op_B_out),
    .fpu_data_in   (fpu_data_in),
    .fpu_status_in (fpu_status_in),
    .result_out    (result_out),
    .status_out    (status_out),
    .result_valid  (result_valid),
    .result_ack    (result_ack),
    .busy          (busy),
    .state_dbg     (state_dbg)
  );

  // Clock and edge counter.
  always #5 clock100KHz = ~clock100KHz;
  always @(posedge clock100KHz) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: on every rise of result_valid pop and compare.
  logic        prev_rv = 1'b0;
  logic [67:0] mon_e;
  always @(negedge clock100KHz) begin
    if (reset && result_valid && !prev_rv) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result got %h want none", result_out);
      end else begin
        mon_e = exp_q.pop_front();
        check("result_edge", cyc, mon_e[67:36]);
        check("result_out", result_out, mon_e[31:0]);
        check("status_out", 32'(status_out), 32'(mon_e[35:32]));
        model_res  = mon_e[31:0];
        model_stat = mon_e[35:32];
      end
    end
    prev_rv <= result_valid;
  end

  // Offer one byte after 'gap' idle cycles; returns the edge that took it.
  task automatic send_byte(input logic [7:0] b, input int gap, output int acc_cyc);
    bit   done;
    logic rdy;
    done    = 1'b0;
    acc_cyc = 0;
    repeat (gap) @(negedge clock100KHz);
    @(negedge clock100KHz);
    byte_in    = b;
    byte_valid = 1'b1;
    for (int k = 0; k < 64 && !done; k++) begin
      rdy = byte_ready;
      @(posedge clock100KHz);
      #1;
      if (rdy) begin
        done    = 1'b1;
        acc_cyc = cyc;
      end
    end
    byte_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL byte_accept_timeout got none want accept of %h", b);
    end
  endtask

  // Send a 4-byte operand and check the target register against the model.
  task automatic load_word(input bit is_b, input logic [31:0] w, input int gmin, input int gmax);
    int ac;
    for (int i = 0; i < 4; i++) begin
      send_byte(w[31-8*i -: 8], int'($urandom_range(gmax, gmin)), ac);
      if (i < 3) begin
        if (is_b) check("op_B_partial", op_B_out, model_b);
        else      check("op_A_partial", op_A_out, model_a);
      end
    end
    if (!is_b) begin
      model_a = w;
      check("op_A_out", op_A_out, model_a);
      check("state_after_A", 32'(state_dbg), 32'(LOAD_B));
    end else begin
      model_b = w;
      check("op_B_out", op_B_out, model_b);
      check("busy_after_B", 32'(busy), 32'd1);
      exp_q.push_back({32'(ac + HOLD + 1), fpu_status_in, fpu_data_in});
    end
  endtask

  task automatic transaction(input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] data, input logic [3:0] stat,
                             input int gmin, input int gmax);
    fpu_data_in   = data;
    fpu_status_in = stat;
    load_word(1'b0, a, gmin, gmax);
    load_word(1'b1, b, gmin, gmax);
  endtask

  task automatic wait_result();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < HOLD + 40 && !ok; k++) begin
      @(negedge clock100KHz);
      if (result_valid) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL result_valid_timeout got 0 want 1");
    end
  endtask

  task automatic ack_result(input int delay);
    repeat (delay) @(negedge clock100KHz);
    @(negedge clock100KHz);
    result_ack = 1'b1;
    @(posedge clock100KHz);
    #1;
    result_ack = 1'b0;
    check("rv_after_ack", 32'(result_valid), 32'd0);
    check("busy_after_ack", 32'(busy), 32'd0);
    check("ready_after_ack", 32'(byte_ready), 32'd1);
    check("result_retained", result_out, model_res);
    check("status_retained", 32'(status_out), 32'(model_stat));
    check("op_A_retained", op_A_out, model_a);
    check("op_B_retained", op_B_out, model_b);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_byte_ready"}, 32'(byte_ready), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_op_A"}, op_A_out, 32'd0);
    check({tag, "_op_B"}, op_B_out, 32'd0);
    check({tag, "_result"}, result_out, 32'd0);
    check({tag, "_status"}, 32'(status_out), 32'd0);
    check({tag, "_rv"}, 32'(result_valid), 32'd0);
    check({tag, "_state"}, 32'(state_dbg), 32'(LOAD_A));
  endtask

  // Asynchronous reset pulse placed mid-cycle; pending results are dropped.
  task automatic pulse_reset(input string tag);
    #2;
    reset = 1'b0;
    #1;
    exp_q.delete();
    model_a = '0; model_b = '0; model_res = '0; model_stat = '0;
    check_reset_state(tag);
    repeat (2) @(negedge clock100KHz);
    reset = 1'b1;
  endtask

  initial begin
    int ac;
    int bp_cycles;
    bit seen_rv;
    logic [31:0] ra;

    // Power-on reset.
    reset = 1'b0;
    repeat (2) @(posedge clock100KHz);
    #1;
    check_reset_state("por");
    @(negedge clock100KHz);
    reset = 1'b1;

    // Directed 1.0 and 2.0 with result 3.0/EXACT, byte bus pushed with 0xFF
    // and result_ack pulsed during HOLD, then backpressure into DONE.
    transaction(32'h3E000000, 32'h40000000, 32'h41000000, EXACT, 0, 0);
    byte_in    = 8'hFF;
    byte_valid = 1'b1;
    result_ack = 1'b1;
    seen_rv    = 1'b0;
    bp_cycles  = 0;
    for (int k = 0; k < HOLD + 40 && bp_cycles < 3; k++) begin
      @(negedge clock100KHz);
      if (k == 2) result_ack = 1'b0;
      check("bp_byte_ready", 32'(byte_ready), 32'd0);
      check("bp_op_A", op_A_out, model_a);
      check("bp_op_B", op_B_out, model_b);
      if (result_valid) seen_rv = 1'b1;
      if (seen_rv) bp_cycles++;
    end
    byte_valid = 1'b0;
    check("bp_rv_held", 32'(result_valid), 32'd1);
    ack_result(0);

    // Gapped byte stream, one idle cycle between bytes.
    transaction(32'h3F800000, 32'hC0400000, 32'h12345678, INEXACT, 1, 1);
    wait_result();
    ack_result(2);

    // Reset in the middle of HOLD.
    transaction($urandom, $urandom, 32'hDEADBEEF, OVERFLOW, 0, 1);
    repeat (4) @(negedge clock100KHz);
    pulse_reset("rst_hold");

    // Reset after two bytes of B: the next word must load A again.
    load_word(1'b0, $urandom, 0, 2);
    send_byte(8'hAB, 0, ac);
    send_byte(8'hCD, 1, ac);
    pulse_reset("rst_b");
    load_word(1'b0, 32'h3F800000, 0, 0);
    fpu_data_in   = 32'h0BADF00D;
    fpu_status_in = UNDERFLOW;
    load_word(1'b1, $urandom, 0, 0);
    wait_result();
    ack_result(1);

    // Randomized transactions.
    for (int t = 0; t < 15; t++) begin
      ra = $urandom;
      transaction(ra, $urandom, $urandom, 4'b0001 << $urandom_range(3, 0), 0, 3);
      wait_result();
      ack_result(int'($urandom_range(4, 0)));
    end

    repeat (5) @(negedge clock100KHz);
    check("pending_results", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpu_operand_loader.md
FPU_OPERAND_LOADER -- requirements
Module: fpu_operand_loader

Interface
REQ-001 SHALL have parameter: HOLD_CYCLES, 10, cycles operands are held stable at the FPU before the result is captured (legal range 1..255; 10 covers two full 5-state FPU passes).
REQ-002 SHALL have port: clock100KHz  in  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port: byte_in  in  8  operand byte stream, MSB byte first, A then B.
REQ-005 SHALL have port: byte_valid  in  1  byte_in valid.
REQ-006 SHALL have port: byte_ready  out  1  loader accepts a byte this cycle.
REQ-007 SHALL have port: op_A_out  out  32  operand A to FPU (1 sign, 6 exp bias 31, 25 mantissa).
REQ-008 SHALL have port: op_B_out  out  32  operand B to FPU, same format.
REQ-009 SHALL have port: fpu_data_in  in  32  FPU result word.
REQ-010 SHALL have port: fpu_status_in  in  4  FPU status code.
REQ-011 SHALL have port: result_out  out  32  captured result.
REQ-012 SHALL have port: status_out  out  4  captured status.
REQ-013 SHALL have port: result_valid  out  1  captured result available; held until acknowledged.
REQ-014 SHALL have port: result_ack  in  1  consumer acknowledge.
REQ-015 SHALL have port: busy  out  1  high in every state except LOAD_A.

Function
REQ-016 SHALL implement states LOAD_A, LOAD_B, HOLD, CAPTURE, DONE.
REQ-017 byte_ready SHALL be 1 exactly in LOAD_A and LOAD_B; a byte is accepted only when byte_valid && byte_ready.
REQ-018 Accepted bytes SHALL shift into a 32-bit shadow register from the LSB end (first byte ends in bits 31:24); a 2-bit counter SHALL count accepted bytes and wrap 3->0.
REQ-019 Gaps in byte_valid SHALL stall the counter without losing already accepted bytes.
REQ-020 On the 4th accepted byte in LOAD_A, op_A_out SHALL update with the complete word on the same edge and state SHALL go to LOAD_B; op_A_out SHALL never show partial words.
REQ-021 On the 4th accepted byte in LOAD_B, op_B_out SHALL update likewise, the hold counter SHALL load HOLD_CYCLES-1, and state SHALL go to HOLD.
REQ-022 HOLD SHALL decrement the counter each cycle and go to CAPTURE when it reads 0.
REQ-023 CAPTURE SHALL register fpu_data_in into result_out and fpu_status_in into status_out, set result_valid, and go to DONE (one cycle).
REQ-024 DONE SHALL hold all outputs; on result_ack it SHALL clear result_valid and go to LOAD_A on the same edge.
REQ-025 result_ack outside DONE SHALL be ignored; byte_valid outside LOAD_A/LOAD_B SHALL be ignored and no byte consumed.
REQ-026 Latency: result_valid SHALL rise exactly HOLD_CYCLES+1 rising edges after the edge accepting the 8th byte.
REQ-027 op_A_out, op_B_out, result_out, status_out SHALL retain values until next overwrite, including across LOAD_A.

Reset
REQ-028 reset low SHALL immediately force state LOAD_A, byte counter 0, hold counter 0, shadow register, op_A_out, op_B_out, result_out, status_out to 0, result_valid 0; busy therefore 0 and byte_ready 1.
REQ-029 Reset mid-operation SHALL discard partial operands; the next 4 accepted bytes SHALL load A.

Structure
REQ-030 Shared package SHALL hold the state enum, status codes (EXACT 4'b0001, INEXACT 4'b0010, OVERFLOW 4'b0100, UNDERFLOW 4'b1000), FORMAT constants (EXP_W 6, MANT_W 25, BIAS 31).
REQ-031 One sub-module SHALL be natural: byte_shift_collector (shadow register + byte counter, word_done pulse).

Verification
REQ-032 Reset: assert reset low mid-HOLD -> byte_ready=1, busy=0, all data outputs 0x00000000, status_out 0, result_valid 0.
REQ-033 Load: bytes 3E 00 00 00 40 00 00 00 -> op_A_out=0x3E000000 (1.0) after byte 4, op_B_out=0x40000000 (2.0) after byte 8, busy=1.
REQ-034 Capture: bench model drives fpu_data_in=0x41000000 (3.0), status 4'b0001 -> result_valid rises 11 edges after byte 8, result_out=0x41000000, status_out=4'b0001.
REQ-035 Backpressure: byte_valid=1 with 0xFF during HOLD and DONE -> byte_ready=0, op_A_out/op_B_out unchanged.
REQ-036 Handshake: result_ack=1 in DONE -> result_valid=0 next edge, busy=0, result_out retained; bytes with 1-cycle gaps then load correctly.
REQ-037 Reset after 2 bytes of B -> next 4 bytes 3F 80 00 00 load op_A_out=0x3F800000, state LOAD_B.
